// File: rtl/ntt_defines_pkg.sv
// ntt_defines_pkg: shared NTT datapath sizes and beat types.
//   NTT_REG_SIZE     - coefficient register width in bits
//   NTT_WRBUF_LANES  - coefficients per write-buffer beat
//   ntt_wrbuf_beat_t - one write-buffer beat, element [LANES-1] (MSBs) is coef0
package ntt_defines_pkg;

    localparam int NTT_REG_SIZE    = 24;
    localparam int NTT_WRBUF_LANES = 4;

    typedef logic [NTT_WRBUF_LANES-1:0][NTT_REG_SIZE-1:0] ntt_wrbuf_beat_t;

endpackage

// File: rtl/ntt_wrbuf_transpose.sv
// ntt_wrbuf_transpose: ping-pong 4x4 transpose buffer between butterfly outputs and memory writes.
// Ports:
//   clk, reset_n (async active-low), zeroize (sync clear of everything)
//   wr_valid_i / wr_data_i / wr_ready_o : row beats in, coef0 in MSBs
//   rd_valid_o / rd_data_o / rd_ready_i : transposed column beats out, coef0 in MSBs
//   ovf_err_o : sticky write-while-not-ready flag, built only with NTT_WRBUF_OVF_ERR_EN defined,
//               otherwise tied to 0
module ntt_wrbuf_transpose
    import ntt_defines_pkg::*;
#(
    parameter int REG_W = NTT_REG_SIZE,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   zeroize,
    input  logic                   wr_valid_i,
    input  logic [LANES*REG_W-1:0] wr_data_i,
    output logic                   wr_ready_o,
    output logic                   rd_valid_o,
    output logic [LANES*REG_W-1:0] rd_data_o,
    input  logic                   rd_ready_i,
    output logic                   ovf_err_o
);

    logic [REG_W-1:0] bank_q [2][LANES][LANES];
    logic [REG_W-1:0] bank_d [2][LANES][LANES];
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       wr_row_q, wr_row_d;
    logic [1:0]       rd_col_q, rd_col_d;
    logic             wr_fire, rd_fire;

    logic [LANES-1:0][REG_W-1:0] wr_lanes;
    logic [LANES-1:0][REG_W-1:0] rd_lanes;

    assign wr_lanes   = wr_data_i;
    assign wr_ready_o = !full_q[wr_bank_q];
    assign rd_valid_o = full_q[rd_bank_q];
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign rd_fire    = rd_valid_o && rd_ready_i;
    assign rd_data_o  = rd_lanes;

    // Output lane j is row j of the current column; lane 0 lives in the MSBs.
    always_comb begin
        rd_lanes = '0;
        for (int j = 0; j < LANES; j++) begin
            rd_lanes[LANES-1-j] = bank_q[rd_bank_q][j][rd_col_q];
        end
    end

    // The write and read sides only ever touch different banks: a bank is written
    // while not full and read only while full, so the two updates never collide.
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        if (wr_fire) begin
            for (int j = 0; j < LANES; j++) begin
                bank_d[wr_bank_q][wr_row_q][j] = wr_lanes[LANES-1-j];
            end
            wr_row_d = wr_row_q + 2'd1;
            if (wr_row_q == 2'd3) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_fire) begin
            rd_col_d = rd_col_q + 2'd1;
            if (rd_col_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
        if (zeroize) begin
            bank_d    = '{default: '0};
            full_d    = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_row_d  = '0;
            rd_col_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q    <= '{default: '0};
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_col_q  <= '0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

`ifdef NTT_WRBUF_OVF_ERR_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = zeroize ? 1'b0 : (ovf_q || (wr_valid_i && !wr_ready_o));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_err_o = ovf_q;
`else
    assign ovf_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_wrbuf_transpose.sv
// tb_ntt_wrbuf_transpose: self-checking bench for ntt_wrbuf_transpose against a row/column queue model.
module tb_ntt_wrbuf_transpose;
    import ntt_defines_pkg::*;

    localparam int W = NTT_REG_SIZE;
`ifdef NTT_WRBUF_OVF_ERR_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n, zeroize, wr_valid_i, rd_ready_i;
    ntt_wrbuf_beat_t wr_data_i, rd_data_o;
    logic            wr_ready_o, rd_valid_o, ovf_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    ntt_wrbuf_beat_t exp_out[$];
    ntt_wrbuf_beat_t rows[$];
    int              full_cnt;
    int              col_cnt;
    bit              exp_ovf;

    ntt_wrbuf_transpose dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .zeroize    (zeroize),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .rd_ready_i (rd_ready_i),
        .ovf_err_o  (ovf_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic ntt_wrbuf_beat_t rand_beat();
        ntt_wrbuf_beat_t b;
        for (int i = 0; i < 4; i++) b[i] = W'($urandom);
        return b;
    endfunction

    function automatic void model_clear();
        exp_out.delete();
        rows.delete();
        full_cnt = 0;
        col_cnt  = 0;
        exp_ovf  = 1'b0;
    endfunction

    // Model: buffer holds at most two completed 4-row blocks; each completed block
    // becomes four column beats, column c lane j = coefficient c of row j.
    task automatic tick();
        bit              acc_w, acc_r;
        ntt_wrbuf_beat_t col;
        if (zeroize) begin
            model_clear();
        end else begin
            acc_w = wr_valid_i && (full_cnt < 2);
            acc_r = rd_ready_i && (full_cnt > 0);
            if (wr_valid_i && !acc_w && OVF_EN) exp_ovf = 1'b1;
            if (acc_r) begin
                void'(exp_out.pop_front());
                col_cnt++;
                if (col_cnt == 4) begin
                    col_cnt = 0;
                    full_cnt--;
                end
            end
            if (acc_w) begin
                rows.push_back(wr_data_i);
                if (rows.size() == 4) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int j = 0; j < 4; j++) col[3-j] = rows[j][3-c];
                        exp_out.push_back(col);
                    end
                    rows.delete();
                    full_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b1;
        for (int i = 0; i < 20 && full_cnt > 0; i++) tick();
        rd_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        zeroize    = 1'b0;
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
        rd_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
        n_tests++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready_o); end
        n_tests++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid_o); end
        n_tests++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data_o); end
        n_tests++; if (ovf_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_err_o); end
    endtask

    task automatic test_directed();
        ntt_wrbuf_beat_t e;
        rd_ready_i = 1'b1;
        wr_valid_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) wr_data_i[3-j] = W'(4*r + j + 1);
            n_tests++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL dir_wr_ready row %0d got %b want 1", r, wr_ready_o); end
            n_tests++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL dir_early_valid row %0d got %b want 0", r, rd_valid_o); end
            tick();
        end
        wr_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) e[3-j] = W'(4*j + c + 1);
            n_tests++; if (rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL dir_rd_valid col %0d got %b want 1", c, rd_valid_o); end
            n_tests++; if (rd_data_o !== e) begin n_fail++; $display("FAIL dir_col %0d got %h want %h", c, rd_data_o, e); end
            tick();
        end
        n_tests++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL dir_after_valid got %b want 0", rd_valid_o); end
    endtask

    task automatic test_stream();
        int sent = 0, got = 0, ready_low = 0, bubbles = 0, bad = 0;
        bit started = 0;
        rd_ready_i = 1'b1;
        for (int cyc = 0; cyc < 48 && got < 32; cyc++) begin
            wr_valid_i = (sent < 32);
            wr_data_i  = rand_beat();
            if (wr_valid_i && !wr_ready_o) ready_low++;
            if (rd_valid_o) begin
                started = 1;
                if (exp_out.size() == 0 || rd_data_o !== exp_out[0]) bad++;
                got++;
            end else if (started) begin
                bubbles++;
            end
            if (wr_valid_i && wr_ready_o) sent++;
            tick();
        end
        wr_valid_i = 1'b0;
        n_tests++; if (ready_low !== 0) begin n_fail++; $display("FAIL stream_ready_low got %0d want 0", ready_low); end
        n_tests++; if (got !== 32) begin n_fail++; $display("FAIL stream_beats got %0d want 32", got); end
        n_tests++; if (bubbles !== 0) begin n_fail++; $display("FAIL stream_bubbles got %0d want 0", bubbles); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL stream_data bad beats got %0d want 0", bad); end
        drain();
    endtask

    task automatic test_overflow();
        ntt_wrbuf_beat_t first;
        rd_ready_i = 1'b0;
        wr_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data_i = rand_beat();
            n_tests++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL ovf_fill_ready beat %0d got %b want 1", i, wr_ready_o); end
            tick();
        end
        n_tests++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL ovf_full_ready got %b want 0", wr_ready_o); end
        first     = exp_out[0];
        wr_data_i = rand_beat();
        tick();
        wr_valid_i = 1'b0;
        n_tests++; if (ovf_err_o !== OVF_EN) begin n_fail++; $display("FAIL ovf_flag got %b want %b", ovf_err_o, OVF_EN); end
        n_tests++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL ovf_after_ready got %b want 0", wr_ready_o); end
        n_tests++; if (rd_data_o !== first) begin n_fail++; $display("FAIL ovf_head got %h want %h", rd_data_o, first); end
        tick();
        n_tests++; if (ovf_err_o !== OVF_EN) begin n_fail++; $display("FAIL ovf_sticky got %b want %b", ovf_err_o, OVF_EN); end
    endtask

    task automatic test_stall_release();
        ntt_wrbuf_beat_t hold;
        int moved = 0;
        hold = rd_data_o;
        rd_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd_data_o !== hold || rd_valid_o !== 1'b1) moved++;
        end
        n_tests++; if (moved !== 0) begin n_fail++; $display("FAIL stall_stable changes got %0d want 0", moved); end
        rd_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            n_tests++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL rel_ready_early col %0d got %b want 0", c, wr_ready_o); end
            n_tests++; if (rd_data_o !== exp_out[0]) begin n_fail++; $display("FAIL rel_col %0d got %h want %h", c, rd_data_o, exp_out[0]); end
            tick();
        end
        n_tests++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %b want 1", wr_ready_o); end
        for (int c = 0; c < 4; c++) begin
            n_tests++; if (rd_valid_o !== 1'b1 || rd_data_o !== exp_out[0]) begin n_fail++; $display("FAIL rel_bank2 col %0d got %b/%h want 1/%h", c, rd_valid_o, rd_data_o, exp_out[0]); end
            tick();
        end
        n_tests++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL rel_empty got %b want 0", rd_valid_o); end
    endtask

    task automatic test_zeroize();
        rd_ready_i = 1'b0;
        wr_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_data_i = rand_beat();
            tick();
        end
        wr_valid_i = 1'b0;
        zeroize    = 1'b1;
        tick();
        zeroize = 1'b0;
        n_tests++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b want 1", wr_ready_o); end
        n_tests++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_valid got %b want 0", rd_valid_o); end
        n_tests++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL zero_data got %h want 0", rd_data_o); end
        n_tests++; if (ovf_err_o !== 1'b0) begin n_fail++; $display("FAIL zero_ovf got %b want 0", ovf_err_o); end
        wr_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                n_tests++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_residue got %b want 0", rd_valid_o); end
            end
            wr_data_i = rand_beat();
            tick();
        end
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            n_tests++; if (rd_valid_o !== 1'b1 || rd_data_o !== exp_out[0]) begin n_fail++; $display("FAIL zero_fresh col %0d got %b/%h want 1/%h", c, rd_valid_o, rd_data_o, exp_out[0]); end
            tick();
        end
        rd_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        rd_ready_i = 1'b0;
        wr_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data_i = rand_beat();
            tick();
        end
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b1;
        n_tests++; if (rd_data_o !== exp_out[0]) begin n_fail++; $display("FAIL areset_col0 got %h want %h", rd_data_o, exp_out[0]); end
        tick();
        #1 reset_n = 1'b0;
        #1;
        n_tests++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", rd_valid_o); end
        n_tests++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL areset_data got %h want 0", rd_data_o); end
        n_tests++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL areset_ready got %b want 1", wr_ready_o); end
        #1 reset_n = 1'b1;
        model_clear();
        rd_ready_i = 1'b0;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            wr_valid_i = ($urandom_range(0, 3) != 0);
            rd_ready_i = (cyc < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            zeroize    = ($urandom_range(0, 63) == 0);
            wr_data_i  = rand_beat();
            n_tests++; if (wr_ready_o !== (full_cnt < 2)) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, wr_ready_o, full_cnt < 2); end
            n_tests++; if (rd_valid_o !== (full_cnt > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, rd_valid_o, full_cnt > 0); end
            n_tests++; if (ovf_err_o !== exp_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %b want %b", cyc, ovf_err_o, exp_ovf); end
            if (full_cnt > 0) begin
                n_tests++; if (rd_data_o !== exp_out[0]) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, rd_data_o, exp_out[0]); end
            end
            tick();
        end
        zeroize    = 1'b0;
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_overflow();
        test_stall_release();
        test_zeroize();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_wrbuf_transpose.md
NTT_WRBUF_TRANSPOSE -- requirements
Module: ntt_wrbuf_transpose

Interface
REQ-001 SHALL have parameter REG_W, default NTT_REG_SIZE, coefficient width in bits.
REQ-002 SHALL have parameter LANES, default 4, coefficients per beat and rows per bank; fixed at 4.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 zeroize  input  1  synchronous clear of all state and storage.
REQ-006 wr_valid_i  input  1  butterfly output beat valid.
REQ-007 wr_data_i  input  LANES*REG_W  4 coefficients; coef0 in MSBs (bf_uvo_t order u20,u21,v20,v21).
REQ-008 wr_ready_o  output  1  buffer can accept a beat this cycle.
REQ-009 rd_valid_o  output  1  a transposed beat is available for memory write.
REQ-010 rd_data_o  output  LANES*REG_W  transposed column, coef0 in MSBs.
REQ-011 rd_ready_i  input  1  memory write side accepts the beat.
REQ-012 ovf_err_o  output  1  sticky error: wr_valid_i asserted while wr_ready_o low.

Function
REQ-013 SHALL hold two banks (ping-pong), each a 4x4 array of REG_W registers.
REQ-014 SHALL write: on wr_valid_i && wr_ready_o, store wr_data_i into row wr_row of bank wr_bank; wr_row increments mod 4.
REQ-015 SHALL, when row 3 is written, set full[wr_bank] and toggle wr_bank the same edge.
REQ-016 SHALL drive wr_ready_o = !full[wr_bank] combinationally from registered state.
REQ-017 SHALL drive rd_valid_o = full[rd_bank]; rd_data_o lane j = bank[rd_bank][row j][column rd_col].
REQ-018 SHALL read: on rd_valid_o && rd_ready_i, rd_col increments mod 4; on column 3 transfer, clear full[rd_bank] and toggle rd_bank.
REQ-019 SHALL give latency: row 3 written at edge N -> rd_valid_o high after edge N, first column presentable cycle N+1.
REQ-020 SHALL sustain one beat in and one beat out per cycle with no bubbles when rd_ready_i stays high.
REQ-021 SHALL, with both banks full, hold wr_ready_o low; freed bank visible on wr_ready_o the cycle after its last column transfer (no same-cycle bypass).
REQ-022 SHALL hold rd_data_o stable while rd_valid_o && !rd_ready_i.
REQ-023 SHALL ignore writes when wr_ready_o is low (no storage or pointer change).
REQ-024 SHALL allow simultaneous write to one bank and read from the other without interaction.
REQ-025 SHALL not emit partial banks; an incomplete bank (wr_row != 0) waits for more beats.

Reset
REQ-026 SHALL on reset_n low asynchronously clear: banks, full[1:0], wr_bank, rd_bank, wr_row, rd_col, ovf_err_o to 0; hence wr_ready_o=1, rd_valid_o=0, rd_data_o=0.
REQ-027 SHALL apply identical clearing synchronously on zeroize, including mid-bank (partial data discarded).

Configuration
REQ-028 SHALL compile ovf_err_o logic only when NTT_WRBUF_OVF_ERR_EN is defined: flag sets on wr_valid_i && !wr_ready_o, clears only on reset/zeroize.
REQ-029 SHALL, without NTT_WRBUF_OVF_ERR_EN, keep the port and tie ovf_err_o to 0.

Structure
REQ-030 SHALL take REG_W default and a new typedef ntt_wrbuf_beat_t (4 x NTT_REG_SIZE packed) from ntt_defines_pkg; no module-local typedefs shared elsewhere.
REQ-031 SHALL be a single module; no sub-module.

Verification
REQ-032 Reset then 4 beats rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, rd_ready_i=1 -> rd_valid_o next cycle; outputs {1,5,9,13},{2,6,10,14},{3,7,11,15},{4,8,12,16}.
REQ-033 Continuous 32 beats, rd_ready_i=1 -> wr_ready_o never low, 32 transposed beats, zero bubbles after first.
REQ-034 rd_ready_i=0, 8 beats -> wr_ready_o low after 8th; 9th beat dropped; with macro ovf_err_o=1, without macro 0.
REQ-035 Both full, rd_ready_i raised -> wr_ready_o rises one cycle after 4th column transfer; rd_data_o stable during stall.
REQ-036 2 beats written then zeroize -> full=0, wr_ready_o=1, rd_valid_o=0; next 4 beats form a fresh bank with no residue.
REQ-037 reset_n dropped mid-read -> outputs zero immediately, asynchronously, before next clock edge.
